// File: rtl/keypad_debounce_encoder_if.sv
// Keypad front-end bus: raw key lines and enable in, debounced key status out.
interface keypad_debounce_encoder_if #(
  parameter int N_KEYS = 10,
  parameter int CODE_W = 4
);
  logic [N_KEYS-1:0] keypad;
  logic              enablen;
  logic [CODE_W-1:0] code_out;
  logic              loadn;
  logic              key_strobe;
  logic              multi_key;

  modport master (
    output keypad, enablen,
    input  code_out, loadn, key_strobe, multi_key
  );

  modport slave (
    input  keypad, enablen,
    output code_out, loadn, key_strobe, multi_key
  );
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: synchronise raw key lines, priority-encode (highest index wins),
// debounce the encoded code, and report accepted key, hold flag, strobe and multi-key.
module keypad_debounce_encoder #(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int REPEAT_CYCLES   = 0
) (
  input logic                     clk,
  input logic                     clrn,
  keypad_debounce_encoder_if.slave bus
);

  localparam int MAX_C = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0]  D_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  R_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [N_KEYS-1:0] LSB_ONE = N_KEYS'(1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  // Highest active line wins; a later (higher) index overrides earlier matches.
  function automatic logic [CODE_W-1:0] prio_enc(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

  logic [N_KEYS-1:0] sync_p0, sync_p1;
  logic [CODE_W-1:0] enc;
  logic              any;
  logic              multi_r;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, rpt, rpt_n;
  logic [CODE_W-1:0] cand, cand_n, code_r, code_n;
  logic              loadn_r, loadn_n, strobe_r, strobe_n;

  // Stage p0/p1: two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.keypad;
      sync_p1 <= sync_p0;
    end
  end

  // Combinational encode of the synchronised lines.
  always_comb begin
    enc = prio_enc(sync_p1);
    any = |sync_p1;
  end

  // Multi-key flag: clearing the lowest set bit leaves something iff two or more lines are active.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) multi_r <= 1'b0;
    else       multi_r <= !bus.enablen && (|(sync_p1 & (sync_p1 - LSB_ONE)));
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      cnt      <= '0;
      rpt      <= '0;
      cand     <= '0;
      code_r   <= '0;
      loadn_r  <= 1'b1;
      strobe_r <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rpt      <= rpt_n;
      cand     <= cand_n;
      code_r   <= code_n;
      loadn_r  <= loadn_n;
      strobe_r <= strobe_n;
    end
  end

  // Debounce FSM next-state logic; the strobe is a pulse so it defaults low every cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rpt_n    = rpt;
    cand_n   = cand;
    code_n   = code_r;
    loadn_n  = loadn_r;
    strobe_n = 1'b0;
    if (bus.enablen) begin
      state_n = IDLE;
      loadn_n = 1'b1;
      cnt_n   = '0;
      rpt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state_n = PRESS;
            cand_n  = enc;
            cnt_n   = CNT_ONE;
          end
        end
        PRESS: begin
          if (!any) begin
            state_n = IDLE;
          end else if (enc == cand) begin
            if (cnt == D_LAST) begin
              state_n  = HELD;
              code_n   = cand;
              loadn_n  = 1'b0;
              strobe_n = 1'b1;
              rpt_n    = '0;
            end else begin
              cnt_n = cnt + CNT_ONE;
            end
          end else begin
            cand_n = enc;
            cnt_n  = CNT_ONE;
          end
        end
        HELD: begin
          if (any && (enc == code_r)) begin
            if (REPEAT_CYCLES > 0) begin
              if (rpt == R_LAST) begin
                strobe_n = 1'b1;
                rpt_n    = '0;
              end else begin
                rpt_n = rpt + CNT_ONE;
              end
            end
          end else begin
            state_n = RELEASE;
            cnt_n   = CNT_ONE;
          end
        end
        RELEASE: begin
          // Only the same key resumes the hold; any other key must re-debounce from IDLE.
          if (any && (enc == code_r)) begin
            state_n = HELD;
          end else if (cnt == D_LAST) begin
            state_n = IDLE;
            loadn_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.code_out   = code_r;
  assign bus.loadn      = loadn_r;
  assign bus.key_strobe = strobe_r;
  assign bus.multi_key  = multi_r;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench: DUT a has no auto-repeat, DUT b repeats every 8 cycles; both debounce over 4.
module tb_keypad_debounce_encoder;

  logic       clk = 1'b0;
  logic       clrn;
  logic [9:0] keypad;
  logic       enablen;
  int         errors = 0;
  int         checks = 0;
  int         sa, sb;

  keypad_debounce_encoder_if #(.N_KEYS(10), .CODE_W(4)) ifa ();
  keypad_debounce_encoder_if #(.N_KEYS(10), .CODE_W(4)) ifb ();

  assign ifa.keypad  = keypad;
  assign ifa.enablen = enablen;
  assign ifb.keypad  = keypad;
  assign ifb.enablen = enablen;

  keypad_debounce_encoder #(.N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0))
    dut_a (.clk(clk), .clrn(clrn), .bus(ifa));
  keypad_debounce_encoder #(.N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8))
    dut_b (.clk(clk), .clrn(clrn), .bus(ifb));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, counting strobes on each DUT.
  task automatic run_count(input int n, output int ca, output int cb);
    ca = 0;
    cb = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ifa.key_strobe === 1'b1) ca++;
      if (ifb.key_strobe === 1'b1) cb++;
    end
  endtask

  initial begin
    clrn    = 1'b0;
    keypad  = '0;
    enablen = 1'b0;
    tick(2);
    chk("rst_code", ifa.code_out, 4'd0);
    chk("rst_loadn", ifa.loadn, 1'b1);
    chk("rst_strobe", ifa.key_strobe, 1'b0);
    chk("rst_multi", ifa.multi_key, 1'b0);
    clrn = 1'b1;
    tick(2);

    // Clean press and release of key 7.
    keypad = 10'd1 << 7;
    run_count(5, sa, sb);
    chk("k7_early_strobes", sa, 0);
    chk("k7_early_loadn", ifa.loadn, 1'b1);
    tick(1);
    chk("k7_acc_loadn", ifa.loadn, 1'b0);
    chk("k7_acc_strobe", ifa.key_strobe, 1'b1);
    chk("k7_acc_code", ifa.code_out, 4'd7);
    tick(1);
    chk("k7_strobe_1cyc", ifa.key_strobe, 1'b0);
    chk("k7_hold_loadn", ifa.loadn, 1'b0);
    keypad = '0;
    run_count(5, sa, sb);
    chk("k7_rel_early_loadn", ifa.loadn, 1'b0);
    chk("k7_rel_strobes", sa, 0);
    tick(1);
    chk("k7_rel_loadn", ifa.loadn, 1'b1);
    chk("k7_rel_strobe", ifa.key_strobe, 1'b0);
    chk("k7_rel_code", ifa.code_out, 4'd7);
    tick(3);

    // Key 3 bouncing every 2 cycles, then stable.
    sa = 0;
    for (int p = 0; p < 10; p++) begin
      int ca, cb;
      keypad = (p % 2 == 0) ? (10'd1 << 3) : 10'd0;
      run_count(2, ca, cb);
      sa += ca;
    end
    chk("k3_bounce_strobes", sa, 0);
    chk("k3_bounce_loadn", ifa.loadn, 1'b1);
    keypad = 10'd1 << 3;
    run_count(5, sa, sb);
    chk("k3_early_strobes", sa, 0);
    tick(1);
    chk("k3_acc_strobe", ifa.key_strobe, 1'b1);
    chk("k3_acc_code", ifa.code_out, 4'd3);
    run_count(10, sa, sb);
    chk("k3_no_more_strobes", sa, 0);
    keypad = '0;
    tick(8);
    chk("k3_rel_loadn", ifa.loadn, 1'b1);

    // Keys 2 and 8 together; then drop 8.
    keypad = (10'd1 << 2) | (10'd1 << 8);
    tick(2);
    chk("multi_early", ifa.multi_key, 1'b0);
    tick(1);
    chk("multi_set", ifa.multi_key, 1'b1);
    tick(3);
    chk("k28_acc_strobe", ifa.key_strobe, 1'b1);
    chk("k28_acc_code", ifa.code_out, 4'd8);
    chk("k28_acc_loadn", ifa.loadn, 1'b0);
    keypad = 10'd1 << 2;
    tick(3);
    chk("multi_clear", ifa.multi_key, 1'b0);
    chk("k2_release_loadn", ifa.loadn, 1'b0);
    tick(3);
    chk("k2_idle_loadn", ifa.loadn, 1'b1);
    chk("k2_idle_code", ifa.code_out, 4'd8);
    run_count(3, sa, sb);
    chk("k2_press_strobes", sa, 0);
    tick(1);
    chk("k2_acc_strobe", ifa.key_strobe, 1'b1);
    chk("k2_acc_code", ifa.code_out, 4'd2);
    chk("k2_acc_loadn", ifa.loadn, 1'b0);
    keypad = '0;
    tick(8);
    chk("k2_rel_loadn", ifa.loadn, 1'b1);

    // Disable while holding key 9, then re-enable with key still held.
    keypad = 10'd1 << 9;
    tick(6);
    chk("k9_acc_strobe", ifa.key_strobe, 1'b1);
    chk("k9_acc_code", ifa.code_out, 4'd9);
    tick(2);
    enablen = 1'b1;
    tick(1);
    chk("dis_loadn", ifa.loadn, 1'b1);
    chk("dis_code", ifa.code_out, 4'd9);
    chk("dis_strobe", ifa.key_strobe, 1'b0);
    run_count(3, sa, sb);
    chk("dis_strobes", sa, 0);
    chk("dis_loadn_held", ifa.loadn, 1'b1);
    enablen = 1'b0;
    tick(1);
    chk("en_first_loadn", ifa.loadn, 1'b1);
    run_count(5, sa, sb);
    chk("en_reacc_strobes", sa, 1);
    chk("en_reacc_loadn", ifa.loadn, 1'b0);
    chk("en_reacc_code", ifa.code_out, 4'd9);
    keypad = '0;
    tick(8);
    chk("k9_rel_loadn", ifa.loadn, 1'b1);

    // Asynchronous reset in the middle of a key-4 press.
    keypad = 10'd1 << 4;
    tick(3);
    clrn = 1'b0;
    #1;
    chk("arst_code", ifa.code_out, 4'd0);
    chk("arst_loadn", ifa.loadn, 1'b1);
    chk("arst_strobe", ifa.key_strobe, 1'b0);
    chk("arst_multi", ifa.multi_key, 1'b0);
    tick(1);
    clrn = 1'b1;
    run_count(5, sa, sb);
    chk("arst_early_strobes", sa, 0);
    chk("arst_early_loadn", ifa.loadn, 1'b1);
    tick(1);
    chk("arst_acc_strobe", ifa.key_strobe, 1'b1);
    chk("arst_acc_code", ifa.code_out, 4'd4);
    keypad = '0;
    tick(8);
    chk("k4_rel_loadn", ifa.loadn, 1'b1);

    // Auto-repeat on DUT b with key 5.
    keypad = 10'd1 << 5;
    tick(6);
    chk("rp_acc_strobe", ifb.key_strobe, 1'b1);
    chk("rp_acc_code", ifb.code_out, 4'd5);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      chk($sformatf("rp_strobe_%0d", k), ifb.key_strobe, (k % 8 == 0) ? 1'b1 : 1'b0);
    end
    chk("rp_norep_a", ifa.key_strobe, 1'b0);
    keypad = '0;
    tick(1);
    keypad = 10'd1 << 5;
    sa = 0;
    sb = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (ifb.key_strobe === 1'b1) sb++;
      if (ifb.loadn !== 1'b0) sa++;
    end
    chk("rp_bounce_strobes", sb, 0);
    chk("rp_bounce_loadn_drops", sa, 0);
    tick(1);
    chk("rp_after_bounce_strobe", ifb.key_strobe, 1'b1);
    keypad = '0;
    tick(8);
    chk("rp_rel_loadn", ifb.loadn, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
